// File: rtl/dmem_pkg.sv
// dmem_pkg: shared memory geometry and vector-reader state encoding
// Used by dmem_vreader and by the data memory it reads from.
package dmem_pkg;
  localparam int S = 32;
  localparam int LANES = 6;
  localparam int V = LANES * S;
  localparam int SIZE = 30015;
  typedef enum logic [1:0] {IDLE, FETCH, LAST, RESP} state_t;
endpackage

// File: rtl/dmem_vreader_if.sv
// dmem_vreader_if: request/response handshake plus memory read port of the vector reader
// Ports: req_valid/req_ready/isVector/address (request), mem_re/mem_addr/mem_rdata (memory),
//        resp_valid/resp_ready/rdata/err (response). slave = reader view, master = system view.
interface dmem_vreader_if #(
  parameter int S = dmem_pkg::S,
  parameter int V = dmem_pkg::V
);
  logic req_valid;
  logic req_ready;
  logic isVector;
  logic [S-1:0] address;
  logic mem_re;
  logic [S-1:0] mem_addr;
  logic [S-1:0] mem_rdata;
  logic resp_valid;
  logic resp_ready;
  logic [V-1:0] rdata;
  logic err;
  modport slave (
    input req_valid, isVector, address, mem_rdata, resp_ready,
    output req_ready, mem_re, mem_addr, resp_valid, rdata, err
  );
  modport master (
    output req_valid, isVector, address, mem_rdata, resp_ready,
    input req_ready, mem_re, mem_addr, resp_valid, rdata, err
  );
endinterface

// File: rtl/dmem_vreader.sv
// dmem_vreader: reads one word or a LANES-word vector from data memory and returns it assembled
// Ports: clk, rst (sync, active-high); bus (dmem_vreader_if.slave) carries request handshake,
//        memory read port (one-cycle read latency) and response handshake with rdata/err.
module dmem_vreader #(
  parameter int S = dmem_pkg::S,
  parameter int LANES = dmem_pkg::LANES,
  parameter int V = dmem_pkg::V,
  parameter int SIZE = dmem_pkg::SIZE
) (
  input logic clk,
  input logic rst,
  dmem_vreader_if.slave bus
);
  import dmem_pkg::*;
  localparam int LW = $clog2(LANES + 1);
  state_t state, next;
  logic [LW-1:0] lane, n, n_in;
  logic [S-1:0] base;
  logic is_vec;
  logic [V-1:0] rdata;
  logic err;
  logic [S:0] end_a;
  logic range_err, accept, cap;
  always_comb begin
    n_in = bus.isVector ? LW'(LANES) : LW'(1);
    // end address kept one bit wider so a base near the top of the address space cannot wrap
    end_a = {1'b0, bus.address} + (S+1)'(n_in) - (S+1)'(1);
    range_err = end_a >= (S+1)'(SIZE);
    accept = state == IDLE && bus.req_valid;
    n = is_vec ? LW'(LANES) : LW'(1);
    // data returns one cycle after issue; lane counter is already one ahead, so capture lane-1
    cap = (state == FETCH && lane != '0) || state == LAST;
  end
  always_comb begin
    next = state == IDLE  ? (bus.req_valid ? (range_err ? RESP : FETCH) : IDLE) :
           state == FETCH ? (lane == n - LW'(1) ? LAST : FETCH) :
           state == LAST  ? RESP :
                            (bus.resp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lane <= '0;
      rdata <= '0;
      err <= 1'b0;
      base <= '0;
      is_vec <= 1'b0;
    end else begin
      state <= next;
      if (accept) begin
        lane <= '0;
        rdata <= '0;
        err <= range_err;
        base <= bus.address;
        is_vec <= bus.isVector;
      end else if (state == FETCH) begin
        lane <= lane + LW'(1);
      end
      for (int i = 0; i < LANES; i++)
        if (cap && lane - LW'(1) == LW'(i)) rdata[S*i +: S] <= bus.mem_rdata;
    end
  end
  always_comb begin
    bus.req_ready = state == IDLE;
    bus.mem_re = state == FETCH;
    bus.mem_addr = state == FETCH ? base + S'(lane) : '0;
    bus.resp_valid = state == RESP;
    bus.rdata = rdata;
    bus.err = err;
  end
endmodule

// File: tb/tb_dmem_vreader.sv
// tb_dmem_vreader: randomized and directed self-checking bench for dmem_vreader
module tb_dmem_vreader;
  import dmem_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dmem_vreader_if bus ();
  dmem_vreader dut (.clk(clk), .rst(rst), .bus(bus));
  logic [S-1:0] mem [SIZE];
  int vectors = 0;
  int miscompares = 0;
  always @(posedge clk)
    if (bus.mem_re === 1'b1 && bus.mem_addr < 32'(SIZE)) bus.mem_rdata <= mem[bus.mem_addr[14:0]];

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_read(input string tag, input logic vec, input logic [S-1:0] a, input int bp);
    int n;
    longint endv;
    logic e_err;
    logic [V-1:0] exp_d;
    logic [V-1:0] held;
    int cyc, reads, want_lat;
    logic seen;
    n = vec ? LANES : 1;
    endv = longint'(a) + longint'(n) - 1;
    e_err = endv >= longint'(SIZE);
    exp_d = '0;
    if (!e_err) for (int i = 0; i < n; i++) exp_d[S*i +: S] = mem[int'(a) + i];
    want_lat = e_err ? 1 : n + 2;
    vectors++;
    if (bus.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s idle req_ready: got %b want 1", tag, bus.req_ready);
    end
    bus.req_valid = 1'b1;
    bus.isVector = vec;
    bus.address = a;
    @(posedge clk);
    @(negedge clk);
    cyc = 1;
    reads = 0;
    seen = 1'b0;
    while (!seen && cyc <= 20) begin
      if (bus.resp_valid === 1'b1) seen = 1'b1;
      else begin
        vectors++;
        if (bus.req_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL %s busy req_ready cyc %0d: got %b want 0", tag, cyc, bus.req_ready);
        end
        vectors++;
        if (bus.mem_re === 1'b1) begin
          if (e_err || cyc > n || bus.mem_addr !== a + S'(cyc - 1)) begin
            miscompares++;
            $display("FAIL %s mem_addr cyc %0d: got %0d want %0d (reads allowed %0d)", tag, cyc,
                     bus.mem_addr, a + S'(cyc - 1), e_err ? 0 : n);
          end
          reads++;
        end else if (bus.mem_re !== 1'b0 || bus.mem_addr !== '0) begin
          miscompares++;
          $display("FAIL %s idle mem port cyc %0d: got re=%b addr=%0d want re=0 addr=0", tag, cyc,
                   bus.mem_re, bus.mem_addr);
        end
        bus.req_valid = 1'($urandom_range(0, 1));
        bus.isVector = 1'($urandom_range(0, 1));
        bus.address = $urandom;
        @(posedge clk);
        @(negedge clk);
        cyc++;
      end
    end
    vectors++;
    if (!seen || cyc != want_lat) begin
      miscompares++;
      $display("FAIL %s latency: got %0d (seen=%b) want %0d", tag, cyc, seen, want_lat);
    end
    if (!seen) begin
      do_reset();
      return;
    end
    vectors++;
    if (reads != (e_err ? 0 : n)) begin
      miscompares++;
      $display("FAIL %s read count: got %0d want %0d", tag, reads, e_err ? 0 : n);
    end
    vectors++;
    if (bus.rdata !== exp_d) begin
      miscompares++;
      $display("FAIL %s rdata: got %h want %h", tag, bus.rdata, exp_d);
    end
    vectors++;
    if (bus.err !== e_err) begin
      miscompares++;
      $display("FAIL %s err: got %b want %b", tag, bus.err, e_err);
    end
    held = exp_d;
    bus.req_valid = 1'b1;
    for (int k = 0; k < bp; k++) begin
      bus.isVector = 1'($urandom_range(0, 1));
      bus.address = $urandom;
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (bus.resp_valid !== 1'b1 || bus.rdata !== held || bus.err !== e_err ||
          bus.req_ready !== 1'b0 || bus.mem_re !== 1'b0) begin
        miscompares++;
        $display("FAIL %s hold cyc %0d: got valid=%b err=%b ready=%b re=%b rdata=%h want 1 %b 0 0 %h",
                 tag, k, bus.resp_valid, bus.err, bus.req_ready, bus.mem_re, bus.rdata, e_err, held);
      end
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    bus.req_valid = 1'b0;
    vectors++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.mem_re !== 1'b0) begin
      miscompares++;
      $display("FAIL %s after handshake: got valid=%b ready=%b re=%b want 0 1 0", tag,
               bus.resp_valid, bus.req_ready, bus.mem_re);
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.mem_re !== 1'b0 ||
        bus.rdata !== '0 || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset outputs: got ready=%b valid=%b re=%b err=%b rdata=%h want 1 0 0 0 0",
               bus.req_ready, bus.resp_valid, bus.mem_re, bus.err, bus.rdata);
    end
  endtask

  task automatic test_vector();
    for (int i = 0; i < LANES; i++) mem[100 + i] = 32'h11 * 32'(i + 1);
    run_read("vector", 1'b1, 32'd100, 0);
  endtask

  task automatic test_scalar();
    mem[7] = 32'hDEADBEEF;
    run_read("scalar", 1'b0, 32'd7, 0);
  endtask

  task automatic test_range();
    run_read("range_err_vec", 1'b1, 32'd30010, 0);
    run_read("range_ok_vec", 1'b1, 32'd30009, 0);
    run_read("range_ok_scalar", 1'b0, 32'd30014, 0);
    run_read("range_err_scalar", 1'b0, 32'd30015, 0);
    run_read("range_nowrap", 1'b1, 32'hFFFF_FFFF, 0);
    run_read("range_zero", 1'b1, 32'd0, 0);
  endtask

  task automatic test_backpressure();
    run_read("bp_vector", 1'b1, 32'd500, 5);
    run_read("bp_scalar", 1'b0, 32'd9, 5);
    run_read("bp_error", 1'b1, 32'd30012, 5);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < LANES; i++) mem[200 + i] = $urandom;
    bus.req_valid = 1'b1;
    bus.isVector = 1'b1;
    bus.address = 32'd200;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (bus.mem_re !== 1'b1 || bus.mem_addr !== 32'd202) begin
      miscompares++;
      $display("FAIL reset_mid third fetch: got re=%b addr=%0d want 1 202", bus.mem_re, bus.mem_addr);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (bus.req_ready !== 1'b1 || bus.mem_re !== 1'b0 || bus.resp_valid !== 1'b0 || bus.rdata !== '0) begin
      miscompares++;
      $display("FAIL reset_mid abort: got ready=%b re=%b valid=%b rdata=%h want 1 0 0 0",
               bus.req_ready, bus.mem_re, bus.resp_valid, bus.rdata);
    end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (bus.resp_valid !== 1'b0 || bus.mem_re !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_mid quiet cyc %0d: got valid=%b re=%b want 0 0", k, bus.resp_valid, bus.mem_re);
      end
    end
    run_read("reset_mid_retry", 1'b1, 32'd200, 1);
  endtask

  task automatic test_random();
    logic vec;
    logic [S-1:0] a;
    for (int t = 0; t < 40; t++) begin
      vec = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 2) == 0) ? 32'(SIZE - 8 + int'($urandom_range(0, 10)))
                                      : 32'($urandom_range(0, SIZE - 1));
      run_read($sformatf("random_%0d", t), vec, a, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.isVector = 1'b0;
    bus.address = '0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < SIZE; i++) mem[i] = $urandom;
    @(negedge clk);
    test_reset();
    test_vector();
    test_scalar();
    test_range();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
